// File: rtl/stack_host_driver.sv
// ---------------------------------------------------------------------------
// stack_host_driver
//
// Initiator for the stack command bus (COMMAND / INDEX / shared IO_DATA).
// Takes push / pop / peek requests from core logic over a valid/ready
// handshake, sequences each legal request onto the stack bus, captures
// read data and returns exactly one response per request. A local copy of
// the stack occupancy lets it reject overflow, underflow and out-of-range
// peeks without touching the bus.
//
// Ports
//   CLK        single clock shared with the stack
//   RESET      synchronous active-high reset, sampled on both clock edges
//   REQ_VALID  request present
//   REQ_READY  driver can accept a request (high only in IDLE)
//   REQ_OP     00 nop, 01 push, 10 pop, 11 peek
//   REQ_DATA   push data
//   REQ_INDEX  peek depth, 0 = top of stack
//   RSP_VALID  one-cycle response pulse
//   RSP_DATA   pop/peek result, 0 for nop, push and rejected requests
//   RSP_ERR    request rejected, no bus command was issued
//   COUNT      mirrored stack occupancy, 0..DEPTH
//   COMMAND    bus command to the stack
//   INDEX      bus peek index to the stack
//   IO_DATA    shared data bus, driven here only while COMMAND == push
// ---------------------------------------------------------------------------
module stack_host_driver #(
    parameter int DEPTH = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_OP,
    input  logic [3:0] REQ_DATA,
    input  logic [2:0] REQ_INDEX,
    output logic       RSP_VALID,
    output logic [3:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic [2:0] COUNT,
    output logic [1:0] COMMAND,
    output logic [2:0] INDEX,
    inout  wire  [3:0] IO_DATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    state_t     state;
    state_t     state_nxt;

    // Request latched at accept; held until the response has gone out.
    logic [1:0] op_q;
    logic [3:0] data_q;
    logic [2:0] index_q;
    logic       err_q;
    logic [2:0] count_q;

    // Falling-edge bus launch and read-capture registers.
    logic [1:0] cmd_q;
    logic [2:0] idx_q;
    logic [3:0] drv_q;
    logic [3:0] rd_q;

    logic       accept;
    logic       illegal;

    assign accept = (state == IDLE) && REQ_VALID;

    // Legality is judged against the occupancy at accept time. Since a peek
    // index must be below COUNT, this also rejects indices >= DEPTH and any
    // peek of an empty stack.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        illegal = 1'b0;
        case (REQ_OP)
            OP_PUSH: illegal = (count_q == DEPTH_L);
            OP_POP:  illegal = (count_q == 3'd0);
            OP_PEEK: illegal = (REQ_INDEX >= count_q);
            default: illegal = 1'b0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ_VALID)
                         state_nxt = (REQ_OP == OP_NOP || illegal) ? RESP : LAUNCH;
            LAUNCH:  state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        REQ_READY = (state == IDLE);
        RSP_VALID = (state == RESP);
        RSP_ERR   = (state == RESP) && err_q;
        // Only a successful pop/peek (op[1] set) returns captured data.
        RSP_DATA  = ((state == RESP) && !err_q && op_q[1]) ? rd_q : 4'd0;
    end

    // Request latch and occupancy mirror. COUNT moves on the edge leaving
    // RESP, so a push/pop is counted only once its bus cycle has completed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q    <= OP_NOP;
            data_q  <= 4'd0;
            index_q <= 3'd0;
            err_q   <= 1'b0;
            count_q <= 3'd0;
        end else begin
            if (accept) begin
                op_q    <= REQ_OP;
                data_q  <= REQ_DATA;
                index_q <= (REQ_OP == OP_PEEK) ? REQ_INDEX : 3'd0;
                err_q   <= illegal;
            end
            if (state == RESP && !err_q) begin
                if (op_q == OP_PUSH)     count_q <= count_q + 3'd1;
                else if (op_q == OP_POP) count_q <= count_q - 3'd1;
            end
        end
    end

    // Bus launch on the falling edge: COMMAND set in the middle of LAUNCH is
    // stable across the stack's execute edge (entering EXEC) and through the
    // high phase in which the stack returns read data. The falling edge in
    // EXEC captures that data and returns the bus to idle.
    always_ff @(negedge CLK) begin
        if (RESET) begin
            cmd_q <= OP_NOP;
            idx_q <= 3'd0;
            drv_q <= 4'd0;
            rd_q  <= 4'd0;
        end else begin
            case (state)
                LAUNCH: begin
                    cmd_q <= op_q;
                    idx_q <= index_q;
                    drv_q <= (op_q == OP_PUSH) ? data_q : 4'd0;
                    rd_q  <= 4'd0;
                end
                EXEC: begin
                    if (op_q[1]) rd_q <= IO_DATA;
                    cmd_q <= OP_NOP;
                    idx_q <= 3'd0;
                    drv_q <= 4'd0;
                end
                default: begin
                    cmd_q <= OP_NOP;
                    idx_q <= 3'd0;
                    drv_q <= 4'd0;
                end
            endcase
        end
    end

    assign COMMAND = cmd_q;
    assign INDEX   = idx_q;
    assign COUNT   = count_q;

    // Drive enable is derived from the launched command itself, so the
    // driver can never be on the bus while COMMAND[1] is set.
    assign IO_DATA = (cmd_q == OP_PUSH) ? drv_q : 4'bzzzz;

endmodule

// File: doc/stack_host_driver.md
Name: stack_host_driver

Overview:
- Initiator side of the 5-entry stack command bus (COMMAND / INDEX / shared tri-state IO_DATA).
- Accepts push / pop / peek requests from core logic over a valid/ready handshake and sequences them onto the stack bus with correct half-cycle timing.
- Captures read data returned on IO_DATA and returns one response per request.
- Mirrors stack occupancy so it can reject operations that would make the stack wrap, silently overwrite, or read stale entries.

Parameters:
- DEPTH, 5, stack entry count; must equal the stack's depth. Bounds COUNT and the peek index check.

Ports:
- CLK  in  1  single clock for both blocks.
- RESET  in  1  synchronous, active-high; same net drives the stack's RESET.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  driver can accept a request.
- REQ_OP  in  2  00 nop, 01 push, 10 pop, 11 peek.
- REQ_DATA  in  4  push data.
- REQ_INDEX  in  3  peek depth; 0 = top.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_DATA  out  4  pop/peek result; 0 for nop, push and error responses.
- RSP_ERR  out  1  request rejected; no bus command issued.
- COUNT  out  3  mirrored occupancy, 0..DEPTH.
- COMMAND  out  2  to stack.
- INDEX  out  3  to stack.
- IO_DATA  inout  4  shared bus. Driven only while COMMAND==01; 'z otherwise.

Behaviour:
- Clocking:
  - Control FSM, COUNT and response registers update on the rising edge of CLK.
  - Bus launch registers (COMMAND, INDEX, IO_DATA drive value/enable) and the read-capture register update on the falling edge of CLK.
  - Both edges sample RESET synchronously.
- Why this timing is fixed: the stack executes on the rising edge, then drives IO_DATA only during the high phase while COMMAND[1]=1. Launching on the falling edge keeps COMMAND stable across the execute edge and the following high phase.
- Reset values:
  - REQ_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, COUNT=0.
  - COMMAND=00, INDEX=0, IO_DATA released ('z). FSM goes to IDLE.
- FSM states: IDLE, LAUNCH, EXEC, RESP.
  - IDLE:
    - REQ_READY=1.
    - On REQ_VALID, latch op/data/index and drop REQ_READY.
    - If the request is nop or illegal, go to RESP. Otherwise go to LAUNCH.
  - LAUNCH:
    - The falling edge inside this cycle loads COMMAND=op and INDEX=REQ_INDEX (peek only; else 0).
    - For a push it also drives IO_DATA=REQ_DATA.
    - Next state is EXEC.
  - EXEC:
    - The stack executes at the rising edge entering EXEC.
    - The falling edge inside EXEC captures IO_DATA for pop/peek, then returns COMMAND to 00, INDEX to 0 and IO_DATA to 'z.
    - Next state is RESP.
  - RESP:
    - RSP_VALID=1 for exactly one cycle with RSP_DATA/RSP_ERR.
    - COUNT updates on the edge leaving RESP: push +1, pop -1.
    - Next state is IDLE.
- Latency, accept edge to RSP_VALID: 3 cycles for a legal push/pop/peek; 1 cycle for a nop or a rejected request.
- Throughput: next accept earliest one cycle after RSP_VALID.
- Legality checks, made at accept:
  - push with COUNT==DEPTH → RSP_ERR.
  - pop with COUNT==0 → RSP_ERR.
  - peek with REQ_INDEX >= COUNT → RSP_ERR. This also covers index ≥ DEPTH and every peek on an empty stack.
- Rejected requests leave COMMAND=00, COUNT unchanged and IO_DATA undriven.
- Bus contention rule: the IO_DATA drive enable is true only while the launched COMMAND==01. It must never overlap COMMAND[1]=1.
- No response backpressure: RSP_VALID is a pulse and the consumer must take it.
- Reset mid-operation: from any state, return to the reset values at the next edge. No RSP_VALID is issued for the aborted request. The stack is cleared by the same RESET, so COUNT=0 stays consistent.
- REQ inputs are ignored while REQ_READY=0.

Test Plan:
- Reset, then push 3, 7, 9 back-to-back under constant REQ_VALID → three RSP_VALID with RSP_ERR=0 and RSP_DATA=0, each 3 cycles after accept. COUNT ends at 3. IO_DATA is driven only during the push launch windows.
- After those pushes, peek index 0, then 2 → RSP_DATA=9, then 3. COUNT stays 3. Peek index 3 → RSP_ERR=1 after 1 cycle, COMMAND stays 00.
- Pop ×3 → RSP_DATA 9, 7, 3 and COUNT 2, 1, 0. A 4th pop → RSP_ERR=1, RSP_DATA=0, no bus activity.
- Push 1..5, then push 6 → 6th push gives RSP_ERR=1, COUNT=5. A following pop returns 5.
- Assert RESET during EXEC of a pop with COUNT=2 → no RSP_VALID, COUNT=0, COMMAND=00, IO_DATA 'z. A subsequent pop → RSP_ERR=1.
- Every cycle, check that IO_DATA is never driven by both the driver and the stack (no X on the bus), and that REQ_READY is low from accept through the RSP_VALID cycle.
